packet_injector: RTL and testbench

- Sits directly downstream of the instruction-packet fetch stage (20-entry × 38-bit packet ROM with a PC that advances on a rising PC_UPDATE edge).
- Sequences the fetch stage: resets its PC, reads each packet, and injects valid packets into the data-driven ring using a synchronous valid/ready handshake.
- Stops at the first all-zero (terminator) slot or at the end of the ROM.
- Gives the host a single START/DONE control pair.

---
 rtl/packet_pkg.sv | 33 +++
 rtl/pulse_gen.sv | 28 ++
 rtl/packet_injector.sv | 162 ++++++++++++++++
 tb/tb_packet_injector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Packet field layout and sequencer state encoding shared by the packet injector files.
package packet_pkg;

   localparam int PKT_W    = 38;

   localparam int HDR_HI   = 37;
   localparam int HDR_LO   = 35;
   localparam int COLOR_HI = 34;
   localparam int COLOR_LO = 27;
   localparam int OPC_HI   = 26;
   localparam int OPC_LO   = 20;
   localparam int F_HI     = 19;
   localparam int F_LO     = 16;
   localparam int DATA_HI  = 15;
   localparam int DATA_LO  = 0;

   localparam logic [2:0] HDR_VALID = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSTPC,
      ST_SETTLE,
      ST_CHECK,
      ST_SEND,
      ST_ADVANCE,
      ST_DONE
   } state_e;

   function automatic logic [2:0] pkt_hdr(input logic [PKT_W-1:0] pkt);
      return pkt[HDR_HI:HDR_LO];
   endfunction

endpackage

// File: rtl/pulse_gen.sv
// Registered rising-edge detector: one clean single-cycle pulse per low-to-high
// transition of sig_i, delayed by one clock.
module pulse_gen (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic pulse_o
);

   logic sig_q;
   logic pulse_q;
   logic pulse_d;

   assign pulse_d = sig_i & ~sig_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sig_q   <= sig_i;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/packet_injector.sv
// Walks the fetch-stage packet ROM from slot 0 and injects each valid packet
// into the ring over a valid/ready handshake, stopping at a terminator or ROM end.
module packet_injector
   import packet_pkg::*;
#(
   parameter int DEPTH      = 20,
   parameter int SETTLE_CYC = 2,
   parameter int PC_W       = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [PKT_W-1:0] PACKET_IN,
   input  logic [PC_W-1:0]  PC_IN,
   output logic             FETCH_RST,
   output logic             PC_UPDATE,
   output logic [PKT_W-1:0] PKT_DATA,
   output logic             PKT_VALID,
   input  logic             PKT_READY,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [PC_W:0]    SENT_COUNT
);

   // Handshake: a packet transfers on a rising CLK edge where PKT_VALID and
   // PKT_READY are both high; PKT_DATA/PKT_VALID never change while waiting.
   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
   localparam int SC_W  = PC_W + 1;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [SC_W-1:0]    sent_q;
   logic [SC_W-1:0]    sent_d;
   logic [PKT_W-1:0]   data_q;
   logic               valid_q;
   logic               fetch_rst_q;
   logic               pc_update_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               start_pulse;
   logic               last_slot;
   logic               pkt_zero;
   logic               hdr_bad;

   pulse_gen u_start_edge (
      .clk_i   (CLK),
      .rst_i   (RST),
      .sig_i   (START),
      .pulse_o (start_pulse)
   );

   assign cnt_d     = cnt_q - CNT_W'(1);
   assign sent_d    = sent_q + SC_W'(1);
   assign last_slot = (PC_IN == PC_W'(DEPTH - 1));
   assign pkt_zero  = (PACKET_IN == '0);
   assign hdr_bad   = (pkt_hdr(PACKET_IN) != HDR_VALID);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sent_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         fetch_rst_q <= 1'b0;
         pc_update_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_pulse) begin
                  sent_q      <= '0;
                  err_q       <= 1'b0;
                  done_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  fetch_rst_q <= 1'b1;
                  state_q     <= ST_RSTPC;
               end
            end

            ST_RSTPC: begin
               fetch_rst_q <= 1'b0;
               cnt_q       <= CNT_W'(SETTLE_CYC);
               state_q     <= ST_SETTLE;
            end

            // PC_UPDATE, when issued, occupies the first settle cycle.
            ST_SETTLE: begin
               pc_update_q <= 1'b0;
               cnt_q       <= cnt_d;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (pkt_zero) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (hdr_bad) begin
                  err_q   <= 1'b1;
                  state_q <= ST_ADVANCE;
               end else begin
                  data_q  <= PACKET_IN;
                  valid_q <= 1'b1;
                  state_q <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (PKT_READY) begin
                  sent_q  <= sent_d;
                  valid_q <= 1'b0;
                  state_q <= ST_ADVANCE;
               end
            end

            // Never step past the last ROM slot: the PC would wrap into empty space.
            ST_ADVANCE: begin
               if (last_slot) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  pc_update_q <= 1'b1;
                  cnt_q       <= CNT_W'(SETTLE_CYC);
                  state_q     <= ST_SETTLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign FETCH_RST  = fetch_rst_q;
   assign PC_UPDATE  = pc_update_q;
   assign PKT_DATA   = data_q;
   assign PKT_VALID  = valid_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign SENT_COUNT = sent_q;

   a_pulses_exclusive: assert property (@(posedge CLK) disable iff (RST)
      !(FETCH_RST && PC_UPDATE));

   a_no_pulse_while_valid: assert property (@(posedge CLK) disable iff (RST)
      PKT_VALID |-> !(FETCH_RST || PC_UPDATE));

   a_hold_while_stalled: assert property (@(posedge CLK) disable iff (RST)
      (PKT_VALID && !PKT_READY) |=> (PKT_VALID && $stable(PKT_DATA)));

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: a behavioural fetch stage/ROM, a ring-side monitor
// with scripted back-pressure, a vector table of whole runs and a few hand sequences.
`timescale 1ns/1ps
module tb_packet_injector;
   import packet_pkg::*;

   localparam int DEPTH = 20;
   localparam int PC_W  = 5;

   typedef struct {
      int n_valid;
      int bad_slot;
      int stall_idx;
      int stall_len;
      int exp_sent;
      int exp_err;
      int exp_pcu;
      int exp_last;
      int exp_pc;
      int exp_vlen;
   } vec_t;

   logic             CLK = 1'b0;
   logic             RST;
   logic             START;
   logic [PKT_W-1:0] PACKET_IN;
   logic [PC_W-1:0]  PC_IN;
   logic             FETCH_RST;
   logic             PC_UPDATE;
   logic [PKT_W-1:0] PKT_DATA;
   logic             PKT_VALID;
   logic             PKT_READY = 1'b1;
   logic             BUSY;
   logic             DONE;
   logic             ERR;
   logic [PC_W:0]    SENT_COUNT;

   int checks   = 0;
   int failures = 0;

   packet_injector #(.DEPTH(DEPTH), .SETTLE_CYC(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .PACKET_IN  (PACKET_IN),
      .PC_IN      (PC_IN),
      .FETCH_RST  (FETCH_RST),
      .PC_UPDATE  (PC_UPDATE),
      .PKT_DATA   (PKT_DATA),
      .PKT_VALID  (PKT_VALID),
      .PKT_READY  (PKT_READY),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR),
      .SENT_COUNT (SENT_COUNT)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- fetch stage model ----------------
   logic [PKT_W-1:0] rom [DEPTH];
   logic [PC_W-1:0]  fetch_pc = '0;

   always @(posedge CLK) begin
      if (FETCH_RST)      fetch_pc <= '0;
      else if (PC_UPDATE) fetch_pc <= fetch_pc + 5'd1;
   end

   assign PC_IN     = fetch_pc;
   assign PACKET_IN = (int'(fetch_pc) < DEPTH) ? rom[fetch_pc] : '0;

   function automatic logic [PKT_W-1:0] slot_pkt(input int k, input bit bad);
      logic [2:0] h;
      h = bad ? 3'b011 : HDR_VALID;
      return {h, 8'(k * 17 + 3), 7'(k + 1), 4'(k), 16'(k * 4099 + 16'h1234)};
   endfunction

   // ---------------- ring-side monitor / ready driver ----------------
   logic             mon_clr = 1'b0;
   int               stall_idx = -1;
   int               stall_len = 0;
   int               hs_cnt, pcu_cnt, frst_cnt, inv_err, stab_err, cur_vcyc, stall_vlen;
   logic             held;
   logic [PKT_W-1:0] held_data;
   logic [PKT_W-1:0] obs_q[$];
   logic [PKT_W-1:0] exp_q[$];

   always @(negedge CLK) begin
      if (mon_clr) begin
         hs_cnt     <= 0;
         pcu_cnt    <= 0;
         frst_cnt   <= 0;
         inv_err    <= 0;
         stab_err   <= 0;
         cur_vcyc   <= 0;
         stall_vlen <= 0;
         held       <= 1'b0;
         PKT_READY  <= 1'b1;
         obs_q.delete();
      end else if (RST) begin
         cur_vcyc  <= 0;
         held      <= 1'b0;
         PKT_READY <= 1'b1;
      end else begin
         if (PC_UPDATE) pcu_cnt  <= pcu_cnt + 1;
         if (FETCH_RST) frst_cnt <= frst_cnt + 1;
         if ((PC_UPDATE && FETCH_RST) || (PKT_VALID && (PC_UPDATE || FETCH_RST)))
            inv_err <= inv_err + 1;
         if (PKT_VALID) begin
            if (held && (PKT_DATA !== held_data)) stab_err <= stab_err + 1;
            if (hs_cnt == stall_idx && cur_vcyc < stall_len) begin
               PKT_READY <= 1'b0;
               cur_vcyc  <= cur_vcyc + 1;
               held      <= 1'b1;
            end else begin
               PKT_READY <= 1'b1;
               obs_q.push_back(PKT_DATA);
               hs_cnt    <= hs_cnt + 1;
               cur_vcyc  <= 0;
               held      <= 1'b0;
               if (hs_cnt == stall_idx) stall_vlen <= cur_vcyc + 1;
            end
            held_data <= PKT_DATA;
         end else begin
            PKT_READY <= 1'b1;
            held      <= 1'b0;
            cur_vcyc  <= 0;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic prep(input int n_valid, input int bad_slot, input int s_idx, input int s_len);
      for (int i = 0; i < DEPTH; i++)
         rom[i] = (i < n_valid) ? slot_pkt(i, i == bad_slot) : '0;
      exp_q.delete();
      for (int i = 0; i < n_valid; i++)
         if (i != bad_slot) exp_q.push_back(slot_pkt(i, 1'b0));
      stall_idx = s_idx;
      stall_len = s_len;
      @(posedge CLK);
      mon_clr = 1'b1;
      @(posedge CLK);
      mon_clr = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int c = 0; c < 5000 && !DONE; c++) @(negedge CLK);
      check({name, "_done_seen"}, 64'(DONE), 64'd1);
      @(negedge CLK);
   endtask

   task automatic end_checks(input string name, input int e_sent, input int e_err,
                             input int e_pcu, input int e_last, input int e_pc);
      check({name, "_done"}, 64'(DONE), 64'd1);
      check({name, "_busy"}, 64'(BUSY), 64'd0);
      check({name, "_valid"}, 64'(PKT_VALID), 64'd0);
      check({name, "_sent_count"}, 64'(SENT_COUNT), 64'(e_sent));
      check({name, "_err"}, 64'(ERR), 64'(e_err));
      check({name, "_pc_updates"}, 64'(pcu_cnt), 64'(e_pcu));
      check({name, "_fetch_rsts"}, 64'(frst_cnt), 64'd1);
      check({name, "_pc_in"}, 64'(PC_IN), 64'(e_pc));
      check({name, "_pulse_rules"}, 64'(inv_err), 64'd0);
      check({name, "_stall_stable"}, 64'(stab_err), 64'd0);
      check({name, "_handshakes"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_pkt%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
      if (e_last >= 0)
         check({name, "_last_data"}, 64'(PKT_DATA), 64'(slot_pkt(e_last, 1'b0)));
   endtask

   task automatic run_vec(input vec_t v, input string name);
      prep(v.n_valid, v.bad_slot, v.stall_idx, v.stall_len);
      pulse_start();
      for (int c = 0; c < 20 && !BUSY; c++) @(negedge CLK);
      check({name, "_busy_rise"}, 64'(BUSY), 64'd1);
      wait_done(name);
      end_checks(name, v.exp_sent, v.exp_err, v.exp_pcu, v.exp_last, v.exp_pc);
      if (v.exp_vlen != 0)
         check({name, "_stall_valid_cycles"}, 64'(stall_vlen), 64'(v.exp_vlen));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   vec_t vecs[7];

   initial begin
      // Reaching a terminator slot costs one PC_UPDATE, so N valid slots followed
      // by a zero slot give N pulses; only the last ROM slot ends without one.
      //            n  bad stall len sent err pcu last pc vlen
      vecs[0] = '{ 8, -1, -1,  0,   8,  0,  8,  7,   8, 0};
      vecs[1] = '{ 8, -1,  3,  5,   8,  0,  8,  7,   8, 6};
      vecs[2] = '{ 8,  2, -1,  0,   7,  1,  8,  7,   8, 0};
      vecs[3] = '{20, -1, -1,  0,  20,  0, 19, 19,  19, 0};
      vecs[4] = '{ 8,  7, -1,  0,   7,  1,  8,  6,   8, 0};
      vecs[5] = '{ 0, -1, -1,  0,   0,  0,  0, -1,   0, 0};
      vecs[6] = '{20, 19,  0,  3,  19,  1, 19, 18,  19, 4};

      RST   = 1'b1;
      START = 1'b0;
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
      repeat (3) @(negedge CLK);
      check("reset_outputs",
            64'({FETCH_RST, PC_UPDATE, PKT_DATA, PKT_VALID, BUSY, DONE, ERR, SENT_COUNT}), 64'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check("idle_after_reset", 64'({BUSY, DONE, FETCH_RST}), 64'd0);

      for (int v = 0; v < 7; v++)
         run_vec(vecs[v], $sformatf("vec%0d", v));

      // Restart from DONE (previous run left ERR=1), then a START while busy.
      prep(8, -1, 1, 20);
      pulse_start();
      @(negedge CLK);
      check("restart_busy", 64'(BUSY), 64'd1);
      check("restart_done_low", 64'(DONE), 64'd0);
      check("restart_sent_cleared", 64'(SENT_COUNT), 64'd0);
      check("restart_err_cleared", 64'(ERR), 64'd0);
      for (int c = 0; c < 500 && !(hs_cnt == 1 && PKT_VALID); c++) @(negedge CLK);
      check("reach_stall1", 64'(hs_cnt == 1 && PKT_VALID), 64'd1);
      pulse_start();
      wait_done("busy_start");
      end_checks("busy_start", 8, 0, 8, 7, 8);

      // Reset while holding packet 4 in SEND.
      prep(8, -1, 4, 1000);
      pulse_start();
      for (int c = 0; c < 500 && !(hs_cnt == 4 && PKT_VALID); c++) @(negedge CLK);
      check("reach_send4", 64'(hs_cnt == 4 && PKT_VALID), 64'd1);
      check("send4_data", 64'(PKT_DATA), 64'(slot_pkt(4, 1'b0)));
      @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      check("midrst_valid", 64'(PKT_VALID), 64'd0);
      check("midrst_outputs",
            64'({FETCH_RST, PC_UPDATE, PKT_DATA, PKT_VALID, BUSY, DONE, ERR, SENT_COUNT}), 64'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("midrst_pc_kept", 64'(PC_IN), 64'd4);
      run_vec(vecs[0], "after_rst");
      check("after_rst_first_slot0", 64'(obs_q.size() > 0 ? obs_q[0] : '0),
            64'(slot_pkt(0, 1'b0)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
